sampler_trigger: RTL



---
 rtl/sampler_trigger_if.sv | 18 +
 rtl/sampler_trigger.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sampler_trigger_if.sv
// Configuration bus of sampler_trigger: write/read strobes, register select, write data and registered read data.
interface sampler_trigger_if;
  logic        cfg_write;
  logic        cfg_read;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_writedata;
  logic [31:0] cfg_readdata;

  modport master (
    output cfg_write, cfg_read, cfg_addr, cfg_writedata,
    input  cfg_readdata
  );

  modport slave (
    input  cfg_write, cfg_read, cfg_addr, cfg_writedata,
    output cfg_readdata
  );
endinterface

// File: rtl/sampler_trigger.sv
// Trigger unit ahead of the sampler: registers the probed bus, matches it against MASK/VALUE and raises trig_out after DELAY.
// Define SAMPLER_TRIGGER_EDGE_EN to build rising-edge match mode (CTRL bit1); without it only level matching exists.
module sampler_trigger #(
  parameter int inputBits = 32,
  parameter int countBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [inputBits-1:0] in_data,
  output logic [inputBits-1:0] out_data,
  output logic                 trig_out,
  sampler_trigger_if.slave     cfg_bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DELAY, ST_FIRED} state_t;

  state_t               state_q, state_d;
  logic [inputBits-1:0] in_q, in_d;
  logic [inputBits-1:0] mask_q, mask_d;
  logic [inputBits-1:0] value_q, value_d;
  logic [countBits-1:0] delay_q, delay_d;
  logic [countBits-1:0] cnt_q, cnt_d;
  logic                 trig_q, trig_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 match;
  logic                 cond;
  logic                 edge_mode;
  logic [31:0]          ctrl_word;
  logic                 unused_wdata;

`ifdef SAMPLER_TRIGGER_EDGE_EN
  logic edge_q, edge_d;
  logic match_q, match_d;
`endif

  // Upper write-data bits are not decoded by every register or build.
  assign unused_wdata = ^cfg_bus.cfg_writedata;

  assign out_data             = in_q;
  assign trig_out             = trig_q;
  assign cfg_bus.cfg_readdata = rdata_q;

  always_comb begin
    in_d    = in_data;
    mask_d  = mask_q;
    value_d = value_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rdata_d = rdata_q;

    match = (((in_q ^ value_q) & mask_q) == '0);
`ifdef SAMPLER_TRIGGER_EDGE_EN
    edge_d    = edge_q;
    match_d   = match;
    edge_mode = edge_q;
    cond      = edge_q ? (match & ~match_q) : match;
`else
    edge_mode = 1'b0;
    cond      = match;
`endif

    ctrl_word = {28'd0, state_q == ST_FIRED, state_q == ST_DELAY, edge_mode, state_q != ST_IDLE};

    case (state_q)
      ST_ARMED: begin
        if (cond) begin
          if (delay_q == '0) begin
            state_d = ST_FIRED;
          end else begin
            state_d = ST_DELAY;
            cnt_d   = delay_q;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q == countBits'(1)) state_d = ST_FIRED;
        else                        cnt_d   = cnt_q - countBits'(1);
      end
      default: ;
    endcase

    // A CTRL write overrides whatever the FSM would have done this cycle; a running count is left alone.
    if (cfg_bus.cfg_write) begin
      case (cfg_bus.cfg_addr)
        2'd0: begin
          state_d = cfg_bus.cfg_writedata[0] ? ST_ARMED : ST_IDLE;
`ifdef SAMPLER_TRIGGER_EDGE_EN
          edge_d  = cfg_bus.cfg_writedata[1];
`endif
        end
        2'd1:    mask_d  = cfg_bus.cfg_writedata[inputBits-1:0];
        2'd2:    value_d = cfg_bus.cfg_writedata[inputBits-1:0];
        default: delay_d = cfg_bus.cfg_writedata[countBits-1:0];
      endcase
    end else if (cfg_bus.cfg_read) begin
      case (cfg_bus.cfg_addr)
        2'd0:    rdata_d = ctrl_word;
        2'd1:    rdata_d = 32'(mask_q);
        2'd2:    rdata_d = 32'(value_q);
        default: rdata_d = 32'(delay_q);
      endcase
    end

    trig_d = (state_d == ST_FIRED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      mask_q  <= '0;
      value_q <= '0;
      delay_q <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SAMPLER_TRIGGER_EDGE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      match_q <= match_d;
    end
  end
`endif

endmodule
